// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter with a TX FIFO and RAM-compatible registered reads.
// Defining UART_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] w_data,
  input  logic [3:0]  we,
  output logic [31:0] r_data,
  output logic        r_hit,
  output logic        tx,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
`ifdef UART_PARITY_EN
  localparam logic PAR_EN = 1'b1;
`else
  localparam logic PAR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [AW:0] wp_q, wp_d, rp_q, rp_d, count;
  logic ovf_q, ovf_d, r_hit_q;
  logic [31:0] r_data_q, r_data_d, status;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic hit, push_req, push, pop, full, empty, bit_end;
  logic [1:0] sel;
  always_comb begin
    hit      = addr[31:4] == BASE_ADDR[31:4];
    sel      = addr[3:2];
    push_req = hit && sel == 2'd0 && we[0];
    full     = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
    empty    = wp_q == rp_q;
    count    = wp_q - rp_q;
    push     = push_req && !full;
    bit_end  = baud_q == '0;
    pop      = !empty && (state_q == IDLE || (state_q == STOP && bit_end));
    wp_d     = wp_q + {{AW{1'b0}}, push};
    rp_d     = rp_q + {{AW{1'b0}}, pop};
    // A new overflow wins over a clear issued in the same cycle.
    ovf_d    = (push_req && full) || (ovf_q && !(hit && sel == 2'd1 && we[0] && w_data[3]));
    status   = '0;
    status[0] = state_q != IDLE;
    status[1] = full;
    status[2] = empty;
    status[3] = ovf_q;
    status[4] = PAR_EN;
    status[8 +: AW+1] = count;
    r_data_d = (hit && sel == 2'd1) ? status : '0;
  end
  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? BMAX : baud_q - 1'b1;
    bit_d   = bit_q;
    shift_d = pop ? mem_q[rp_q[AW-1:0]] : shift_q;
    case (state_q)
      IDLE: begin
        baud_d = BMAX;
        if (pop) state_d = START;
      end
      START:  if (bit_end) begin state_d = DATA; bit_d = '0; end
      DATA: if (bit_end) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = PAR_EN ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = pop ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      ovf_q    <= 1'b0;
      r_data_q <= '0;
      r_hit_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      ovf_q    <= ovf_d;
      r_data_q <= r_data_d;
      r_hit_q  <= hit;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= w_data[7:0];
  end
  // The shift register is held and indexed by the bit counter, so parity needs no separate register.
  always_comb begin
    tx = state_q == START  ? 1'b0 :
         state_q == DATA   ? shift_q[bit_q] :
         state_q == PARITY ? ^shift_q : 1'b1;
    irq    = empty && state_q == IDLE;
    r_data = r_data_q;
    r_hit  = r_hit_q;
  end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the core's data-memory port, downstream of the execute-stage memory access controller and alongside the data RAM.
- Decodes the word address, byte enables and write data the core drives toward memory.
- Buffers written bytes in a FIFO and serialises them 8N1 on a TX pin.
- Returns status on the registered read path with the same one-cycle read latency as the RAM, so the core's read-data mux treats both identically.

Parameters:
BASE_ADDR, 32'h1000_0000, 16-byte-aligned base of the register window
CLKS_PER_BIT, 868, clock cycles per serial bit (>=2)
FIFO_DEPTH, 16, TX FIFO entries; power of two, >=2

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
addr  input  32  byte address from the memory access controller, presented every cycle
w_data  input  32  write data, already lane-aligned
we  input  4  per-byte write enables; all zero means read or idle
r_data  output  32  registered read data for the previous cycle's addr
r_hit  output  1  registered; 1 when the previous cycle's addr fell in the window
tx  output  1  serial output; idle high
irq  output  1  level; FIFO empty and transmitter idle

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state changes on posedge clk.
- Window decode: hit = (addr[31:4] == BASE_ADDR[31:4]); addr[3:2] selects the register.
  - 0: TXDATA.
  - 1: STATUS.
  - 2, 3: reserved; read 0, writes ignored.
- TXDATA write (hit, sel 0, we[0]=1): push w_data[7:0].
  - If the FIFO is full, the byte is dropped and sticky `ovf` is set.
  - we[3:1] are ignored.
- STATUS read fields:
  - bit0 busy (FSM not IDLE)
  - bit1 full
  - bit2 empty
  - bit3 ovf
  - bits[8+:$clog2(FIFO_DEPTH)+1] fill count
  - all other bits 0
- STATUS write with we[0]=1 and w_data[3]=1 clears ovf. A clear and a new overflow in the same cycle leave ovf set.
- Read path: r_data and r_hit register every cycle from that cycle's addr (no enable); the value is visible after the next edge.
  - Miss or reserved register: r_data=0.
  - Read of TXDATA returns 0.
  - STATUS reflects state before the same edge's update.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the index; full/empty from pointer comparison.
  - Simultaneous push and pop when full: push is dropped (pop has priority for the freed slot only on the next cycle).
  - Simultaneous push and pop when empty: no pop; pop occurs the following cycle.
- TX FSM states: IDLE, START, DATA, STOP. A baud counter reloads to CLKS_PER_BIT-1 on each state entry and bit advance.
  - IDLE: tx=1. If not empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first. Shift at each bit boundary; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - At the end, if not empty: pop and go directly to START (no idle gap).
    - Otherwise go to IDLE.
- Latency: a TXDATA write at edge N into an idle block gives empty=0 after N, pop at N+1, tx=0 after N+1. One frame lasts 10*CLKS_PER_BIT cycles.
- irq = empty & (state==IDLE), combinational from registers.
- Reset values:
  - tx=1, r_data=0, r_hit=0, state=IDLE
  - pointers=0, ovf=0, baud counter and bit index=0
  - irq=1 after reset
  - Reset mid-frame aborts immediately: tx=1 on the next cycle and FIFO contents are discarded.

Optional Feature:
UART_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles with tx = even parity (XOR of the 8 data bits). Frame = 11*CLKS_PER_BIT. STATUS bit4 reads 1.
- Undefined: no PARITY state, 8N1 frame of 10*CLKS_PER_BIT, STATUS bit4 reads 0.

Test Plan:
- CLKS_PER_BIT=4, rst held 3 cycles then released -> tx=1, irq=1, STATUS read returns 32'h0000_0004 (empty only), r_hit=1.
- Write 8'hA5 to BASE+0 with we=4'b0001 -> tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, high 4 cycles; busy=1 during the frame; irq returns to 1 after 40+1 cycles.
- Write 17 bytes back-to-back with FIFO_DEPTH=16 while idle -> first byte popped, 16 buffered, no drop, ovf=0; the 18th write sets ovf (STATUS bit3=1); frames are contiguous with no idle gap between STOP and START.
- STATUS write w_data=32'h8, we=4'b0001 -> ovf cleared; a read of BASE+8 and of 32'h2000_0000 -> r_data=0, r_hit=1 then 0.
- Assert rst during DATA bit 3 of a frame with 5 bytes queued -> next cycle tx=1, STATUS empty=1, count=0, no further frames.
- UART_PARITY_EN defined, send 8'h07 -> parity bit=1 after bit 7, frame 44 cycles at CLKS_PER_BIT=4.
